// File: rtl/jtcps15_outvol_if.sv
// Stereo sample stream between the QSound block, the output gain stage and the mixer.
interface jtcps15_outvol_if;
    logic signed [15:0] left_in;
    logic signed [15:0] right_in;
    logic               sample_in;
    logic signed [15:0] left;
    logic signed [15:0] right;
    logic               sample;
    logic               clip;

    // master: the producer of input samples, which also consumes the results
    modport master (
        output left_in, right_in, sample_in,
        input  left, right, sample, clip
    );

    // slave: the gain stage itself
    modport slave (
        input  left_in, right_in, sample_in,
        output left, right, sample, clip
    );
endinterface

// File: rtl/jtcps15_outvol.sv
// Output gain stage: user volume in 2 dB steps, rounding and saturation,
// one multiplier shared between the left and right channels.
module jtcps15_outvol #(
    parameter int DEF_IDX = 16,
    parameter int REPEAT  = 12_000_000,
    parameter int RW      = 24
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                vol_up,
    input  logic                vol_down,
    jtcps15_outvol_if.slave     aud,
    output logic                overrun,
    output logic [4:0]          vol_idx
);
    localparam logic [4:0] MAX_IDX = 5'd19;

    typedef enum logic [1:0] { IDLE, MULL, MULR, OUT } state_t;

    state_t             state, nxt;
    logic [4:0]         pend;
    logic               up_l, dn_l;
    logic [RW-1:0]      rcnt;
    logic signed [15:0] lat_l, lat_r;
    logic [15:0]        gain;
    logic signed [15:0] res_l;
    logic               sat_l;

    // Unity is 16'h4000; idx n gives 2*(n-16) dB, idx 0 is mute.
    function automatic logic [15:0] gain_of(input logic [4:0] i);
        case (i)
            5'd1:    gain_of = 16'd518;
            5'd2:    gain_of = 16'd652;
            5'd3:    gain_of = 16'd821;
            5'd4:    gain_of = 16'd1034;
            5'd5:    gain_of = 16'd1301;
            5'd6:    gain_of = 16'd1638;
            5'd7:    gain_of = 16'd2063;
            5'd8:    gain_of = 16'd2597;
            5'd9:    gain_of = 16'd3269;
            5'd10:   gain_of = 16'd4115;
            5'd11:   gain_of = 16'd5181;
            5'd12:   gain_of = 16'd6523;
            5'd13:   gain_of = 16'd8211;
            5'd14:   gain_of = 16'd10338;
            5'd15:   gain_of = 16'd13014;
            5'd16:   gain_of = 16'd16384;
            5'd17:   gain_of = 16'd20626;
            5'd18:   gain_of = 16'd25967;
            5'd19:   gain_of = 16'd32690;
            default: gain_of = 16'd0;
        endcase
    endfunction

    // Shared multiplier: operand picked by state, then half-up round and saturate.
    logic signed [32:0] mul_a, mul_g, prod, shr;
    logic signed [15:0] sat_val;
    logic               sat_flag;

    always_comb begin
        mul_a    = (state == MULR) ? 33'(lat_r) : 33'(lat_l);
        mul_g    = $signed({17'd0, gain});
        prod     = mul_a * mul_g;
        shr      = (prod + 33'sd8192) >>> 14;
        sat_flag = 1'b1;
        if (shr > 33'sd32767)
            sat_val = 16'sh7fff;
        else if (shr < -33'sd32768)
            sat_val = 16'sh8000;
        else begin
            sat_val  = shr[15:0];
            sat_flag = 1'b0;
        end
    end

    // Key handling: step on edges, auto-repeat while one key is held alone.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend <= 5'(DEF_IDX);
            up_l <= 1'b0;
            dn_l <= 1'b0;
            rcnt <= '0;
        end else begin
            up_l <= vol_up;
            dn_l <= vol_down;
            if (vol_up && vol_down) begin
                rcnt <= '0;
            end else if (vol_up) begin
                if (!up_l || rcnt == RW'(REPEAT - 1)) begin
                    rcnt <= '0;
                    if (pend != MAX_IDX) pend <= pend + 5'd1;
                end else begin
                    rcnt <= rcnt + 1'b1;
                end
            end else if (vol_down) begin
                if (!dn_l || rcnt == RW'(REPEAT - 1)) begin
                    rcnt <= '0;
                    if (pend != 5'd0) pend <= pend - 5'd1;
                end else begin
                    rcnt <= rcnt + 1'b1;
                end
            end else begin
                rcnt <= '0;
            end
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= nxt;
    end

    // Next state: one cycle per stage once a sample is accepted.
    always_comb begin
        nxt = state;
        case (state)
            IDLE: if (aud.sample_in) nxt = MULL;
            MULL: nxt = MULR;
            MULR: nxt = OUT;
            OUT:  nxt = IDLE;
            default: nxt = IDLE;
        endcase
    end

    // Datapath: latch on accept, left result in MULL, publish both in MULR so
    // the strobe is high exactly while in OUT.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lat_l      <= '0;
            lat_r      <= '0;
            gain       <= '0;
            res_l      <= '0;
            sat_l      <= 1'b0;
            vol_idx    <= 5'(DEF_IDX);
            overrun    <= 1'b0;
            aud.left   <= '0;
            aud.right  <= '0;
            aud.sample <= 1'b0;
            aud.clip   <= 1'b0;
        end else begin
            aud.sample <= 1'b0;
            aud.clip   <= 1'b0;
            if (aud.sample_in && state != IDLE) overrun <= 1'b1;
            case (state)
                IDLE: if (aud.sample_in) begin
                    lat_l   <= aud.left_in;
                    lat_r   <= aud.right_in;
                    gain    <= gain_of(pend);
                    vol_idx <= pend;
                end
                MULL: begin
                    res_l <= sat_val;
                    sat_l <= sat_flag;
                end
                MULR: begin
                    aud.left   <= res_l;
                    aud.right  <= sat_val;
                    aud.sample <= 1'b1;
                    aud.clip   <= sat_l | sat_flag;
                end
                default: ;
            endcase
        end
    end
endmodule
